// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the I-cache request, absorbs misses, stalls and
// redirects, and loads the IF/ID pipeline register with fetched words in PC order.
module if_stage #(
    parameter int              BITS     = 32,
    parameter logic [BITS-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [BITS-1:0] redirect_pc_i,
    output logic            icache_ren,
    output logic [BITS-3:0] icache_addr,
    input  logic            icache_stall,
    input  logic [BITS-1:0] icache_rdata,
    output logic            ifid_valid,
    output logic [BITS-1:0] ifid_inst,
    output logic [BITS-1:0] ifid_pc,
    output logic [6:0]      ifid_opcode,
    output logic [2:0]      ifid_funct3,
    output logic [6:0]      ifid_funct7,
    output logic [1:0]      dbg_state_o
);

    localparam logic [BITS-1:0] NOP = BITS'(32'h0000_0013);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DROP  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [BITS-1:0] pc_q, pc_d;
    logic            ren_q, ren_d;
    logic            valid_q, valid_d;
    logic [BITS-1:0] inst_q, inst_d;
    logic [BITS-1:0] ifpc_q, ifpc_d;
    logic [BITS-1:0] skid_inst_q, skid_inst_d;
    logic [BITS-1:0] skid_pc_q, skid_pc_d;
    logic [BITS-1:0] pend_q, pend_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        inst_d      = inst_q;
        ifpc_d      = ifpc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        pend_d      = pend_q;

        case (state_q)
            ST_FETCH: begin
                if (redirect_i) begin
                    valid_d = 1'b0;
                    inst_d  = NOP;
                    // A miss already in flight must be allowed to finish before the new target.
                    if (ren_q && icache_stall) begin
                        pend_d  = redirect_pc_i;
                        state_d = ST_DROP;
                    end else begin
                        pc_d = redirect_pc_i;
                    end
                end else if (!ren_q) begin
                    state_d = ST_FETCH;
                end else if (icache_stall) begin
                    if (!stall_i) begin
                        valid_d = 1'b0;
                        inst_d  = NOP;
                    end
                end else begin
                    pc_d = pc_q + BITS'(4);
                    if (stall_i) begin
                        skid_inst_d = icache_rdata;
                        skid_pc_d   = pc_q;
                        state_d     = ST_HOLD;
                    end else begin
                        valid_d = 1'b1;
                        inst_d  = icache_rdata;
                        ifpc_d  = pc_q;
                    end
                end
            end

            ST_DROP: begin
                if (redirect_i) begin
                    pend_d  = redirect_pc_i;
                    valid_d = 1'b0;
                    inst_d  = NOP;
                end
                if (!icache_stall) begin
                    pc_d    = redirect_i ? redirect_pc_i : pend_q;
                    state_d = ST_FETCH;
                end
            end

            ST_HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    valid_d = 1'b0;
                    inst_d  = NOP;
                    state_d = ST_FETCH;
                end else if (!stall_i) begin
                    valid_d = 1'b1;
                    inst_d  = skid_inst_q;
                    ifpc_d  = skid_pc_q;
                    state_d = ST_FETCH;
                end
            end

            default: state_d = ST_FETCH;
        endcase

        // Request is registered so it stays low through reset and rises on the first edge after.
        ren_d = (state_d != ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            ren_q       <= 1'b0;
            valid_q     <= 1'b0;
            inst_q      <= NOP;
            ifpc_q      <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ren_q       <= ren_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            ifpc_q      <= ifpc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            pend_q      <= pend_d;
        end
    end

    assign icache_ren  = ren_q;
    assign icache_addr = pc_q[BITS-1:2];
    assign ifid_valid  = valid_q;
    assign ifid_inst   = inst_q;
    assign ifid_pc     = ifpc_q;
    assign ifid_opcode = inst_q[6:0];
    assign ifid_funct3 = inst_q[14:12];
    assign ifid_funct7 = inst_q[31:25];
    assign dbg_state_o = state_q;

endmodule
